// File: rtl/adder_tree_packer.sv
// adder_tree_packer: packs PARALLEL signed samples into one lane vector for the adder tree.
// Define ADDER_TREE_PACKER_SUM_VALID_EN to build the sum_valid delay line; otherwise sum_valid is 0.
module adder_tree_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PARALLEL   = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DATA_WIDTH-1:0]              din,
    input  logic                               din_valid,
    output logic                               din_ready,
    input  logic                               din_last,
    output logic [DATA_WIDTH*PARALLEL-1:0]     dout,
    output logic                               dout_valid,
    input  logic                               dout_ready,
    output logic [$clog2(PARALLEL+1)-1:0]      dout_count,
    output logic                               sum_valid
);

    localparam int CW = $clog2(PARALLEL + 1);
    localparam int IW = $clog2(PARALLEL);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                         state_q, state_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [DATA_WIDTH*PARALLEL-1:0] word_q, word_d;
    logic [CW-1:0]                  count_q, count_d;
    logic                           din_fire;
    logic                           dout_fire;

    assign din_ready  = (state_q == FILL) || dout_ready;
    assign dout_valid = (state_q == HOLD);
    assign din_fire   = din_valid && din_ready;
    assign dout_fire  = dout_valid && dout_ready;
    assign dout       = word_q;
    assign dout_count = count_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        count_d = count_q;
        case (state_q)
            FILL: begin
                if (din_fire) begin
                    // Lane 0 wipes the old word so a short frame leaves zero padding.
                    if (idx_q == '0) word_d = '0;
                    for (int unsigned k = 0; k < PARALLEL; k++) begin
                        if (IW'(k) == idx_q) word_d[k*DATA_WIDTH +: DATA_WIDTH] = din;
                    end
                    if (idx_q == IW'(PARALLEL - 1) || din_last) begin
                        state_d = HOLD;
                        count_d = CW'(idx_q) + CW'(1);
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            HOLD: begin
                if (dout_fire) begin
                    if (din_fire) begin
                        word_d                   = '0;
                        word_d[DATA_WIDTH-1:0]   = din;
                        if (din_last) begin
                            count_d = CW'(1);
                            idx_d   = '0;
                        end else begin
                            state_d = FILL;
                            idx_d   = IW'(1);
                        end
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            word_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

`ifdef ADDER_TREE_PACKER_SUM_VALID_EN
    // One stage per adder tree level, so the strobe lines up with the tree's registered sum.
    localparam int SD = (PARALLEL > 1) ? $clog2(PARALLEL) : 1;

    logic [SD-1:0] sv_q, sv_d;

    assign sv_d = SD'({sv_q, dout_fire});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sv_q <= '0;
        else        sv_q <= sv_d;
    end

    assign sum_valid = sv_q[SD-1];
`else
    assign sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_adder_tree_packer.sv
// Bench for adder_tree_packer: directed cases plus random frames checked against a frame-level scoreboard.
module tb_adder_tree_packer;

    localparam int DW = 8;
    localparam int P  = 5;
    localparam int W  = DW * P;
    localparam int CW = $clog2(P + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          din_last;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [CW-1:0] dout_count;
    logic          sum_valid;

    adder_tree_packer #(.DATA_WIDTH(DW), .PARALLEL(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_last   (din_last),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_count (dout_count),
        .sum_valid  (sum_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] word;
        int           cnt;
    } frame_t;

    logic [DW-1:0] cur[$];
    frame_t        exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            words_out = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    endtask

    // One clock: drive, check outputs against the scoreboard, then advance the model on the edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
        logic   exp_ready;
        logic   in_fire;
        logic   out_fire;
        frame_t f;
        @(negedge clk);
        din_valid  = v;
        din        = d;
        din_last   = l;
        dout_ready = r;
        #1;
        exp_ready = (exp_q.size() == 0) || r;
        chk("din_ready", 64'(din_ready), 64'(exp_ready));
        chk("dout_valid", 64'(dout_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("dout", 64'(dout), 64'(exp_q[0].word));
            chk("dout_count", 64'(dout_count), 64'(exp_q[0].cnt));
        end
        chk("sum_valid", 64'(sum_valid), 64'd0);
        in_fire  = v && exp_ready;
        out_fire = (exp_q.size() != 0) && r;
        @(posedge clk);
        if (out_fire) begin
            void'(exp_q.pop_front());
            words_out++;
        end
        if (in_fire) begin
            cur.push_back(d);
            if (cur.size() == P || l) begin
                f.word = '0;
                foreach (cur[i]) f.word[i*DW +: DW] = cur[i];
                f.cnt = cur.size();
                exp_q.push_back(f);
                cur.delete();
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_dout"}, 64'(dout), 64'd0);
        chk({tag, "_valid"}, 64'(dout_valid), 64'd0);
        chk({tag, "_count"}, 64'(dout_count), 64'd0);
        chk({tag, "_sumv"}, 64'(sum_valid), 64'd0);
        chk({tag, "_ready"}, 64'(din_ready), 64'd1);
    endtask

    initial begin
        int target;
        int cyc;
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        din_last   = 1'b0;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full frame 1..5 back to back.
        for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
        #1;
        chk("word_12345", 64'(dout), 64'h05_04_03_02_01);
        chk("count_5", 64'(dout_count), 64'd5);
        step(1'b0, '0, 1'b0, 1'b1);
        #1;
        chk("valid_pulse", 64'(dout_valid), 64'd0);

        // Short frame -1, 7.
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        step(1'b1, 8'h07, 1'b1, 1'b1);
        #1;
        chk("word_short", 64'(dout), 64'h00_00_00_07_FF);
        chk("count_2", 64'(dout_count), 64'd2);
        step(1'b0, '0, 1'b0, 1'b1);

        // Backpressure: hold the word 4 cycles, then release with sample 9 waiting.
        for (int i = 11; i <= 15; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        repeat (4) step(1'b1, 8'd9, 1'b0, 1'b0);
        chk("word_held", 64'(dout), 64'h0F_0E_0D_0C_0B);
        chk("ready_held", 64'(din_ready), 64'd0);
        step(1'b1, 8'd9, 1'b0, 1'b1);
        for (int i = 2; i <= 5; i++) step(1'b1, DW'(i * 10), 1'b0, 1'b1);
        #1;
        chk("word_after_bp", 64'(dout), 64'h32_28_1E_14_09);
        step(1'b0, '0, 1'b0, 1'b1);

        // Random frames.
        target = words_out + 100;
        cyc = 0;
        while (words_out < target && cyc < 20000) begin
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) != 0);
            cyc++;
        end
        chk("random_frames_done", 64'(words_out >= target), 64'd1);
        step(1'b1, 8'h5A, 1'b1, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);

        // Reset mid-frame.
        for (int i = 1; i <= 3; i++) step(1'b1, DW'(i + 100), 1'b0, 1'b1);
        @(negedge clk);
        din_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_zero("midreset");
        cur.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 31; i <= 35; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
        #1;
        chk("word_post_reset", 64'(dout), 64'h23_22_21_20_1F);
        chk("count_post_reset", 64'(dout_count), 64'd5);
        step(1'b0, '0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
